// File: rtl/pt_ring_inject_arb.sv
// pt_ring_inject_arb: flit-level injection arbiter for one PtRing station.
// Ring through-traffic has priority over NLOC local sources (round-robin).
// The winner holds the link until its tail flit (bit WIDTH-1) is forwarded.
// Optional starvation guard: define PTRING_ARB_STARVE_EN.
module pt_ring_inject_arb #(
   parameter int unsigned WIDTH      = 64,
   parameter int unsigned NLOC       = 4,
   parameter int unsigned STARVE_MAX = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   iRingNotEmpty,
   input  logic [WIDTH-1:0]       iRingDat,
   output logic                   oRingRdEn,
   input  logic [NLOC-1:0]        iLocNotEmpty,
   input  logic [NLOC*WIDTH-1:0]  iLocDat,
   output logic [NLOC-1:0]        oLocRdEn,
   input  logic                   iDnFul,
   output logic                   oDnWrEn,
   output logic [WIDTH-1:0]       oDnWrDat,
   output logic                   oLock,
   output logic                   oStarve
);

   localparam int unsigned IDXW = $clog2(NLOC);

   typedef enum logic [1:0] {IDLE, RING_PKT, LOC_PKT} state_t;

   state_t            state;
   logic [IDXW-1:0]   owner;
   logic [IDXW-1:0]   rr_ptr;
   logic [IDXW-1:0]   rr_next;
   logic [IDXW-1:0]   loc_win;
   logic [IDXW-1:0]   sel_loc;
   logic [IDXW-1:0]   idx;
   logic              loc_found;
   logic              any_loc;
   logic              starving;
   logic              fwd_ring;
   logic              fwd_loc;
   logic              tail;
   logic [WIDTH-1:0]  loc_dat;
   logic [WIDTH-1:0]  fwd_dat;

   assign any_loc = |iLocNotEmpty;

`ifdef PTRING_ARB_STARVE_EN
   localparam int unsigned CW = $clog2(STARVE_MAX + 1);

   logic [CW-1:0] starve_cnt;

   assign starving = (starve_cnt == CW'(STARVE_MAX)) && any_loc;

   // Count ring head wins taken while a local waits; a local head win clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (state == IDLE && fwd_loc) begin
         starve_cnt <= '0;
      end else if (state == IDLE && fwd_ring && any_loc &&
                   starve_cnt != CW'(STARVE_MAX)) begin
         starve_cnt <= starve_cnt + CW'(1);
      end
   end
`else
   assign starving = 1'b0;
`endif

   // Round-robin search for the first requesting local at or above rr_ptr.
   always_comb begin
      loc_found = 1'b0;
      loc_win   = '0;
      idx       = '0;
      for (int unsigned k = 0; k < NLOC; k++) begin
         idx = IDXW'((32'(rr_ptr) + k) % NLOC);
         if (!loc_found && iLocNotEmpty[idx]) begin
            loc_found = 1'b1;
            loc_win   = idx;
         end
      end
   end

   // Forward decision: depends only on state and the empty/full flags.
   always_comb begin
      fwd_ring = 1'b0;
      fwd_loc  = 1'b0;
      sel_loc  = owner;
      case (state)
         IDLE: begin
            if (!iDnFul) begin
               if (iRingNotEmpty && !starving) begin
                  fwd_ring = 1'b1;
               end else if (loc_found) begin
                  fwd_loc = 1'b1;
                  sel_loc = loc_win;
               end
            end
         end
         RING_PKT: fwd_ring = !iDnFul && iRingNotEmpty;
         LOC_PKT:  fwd_loc  = !iDnFul && iLocNotEmpty[owner];
         default: ;
      endcase
   end

   // Head-flit mux for the selected local source.
   always_comb begin
      loc_dat = '0;
      for (int unsigned k = 0; k < NLOC; k++) begin
         if (sel_loc == IDXW'(k)) begin
            loc_dat = iLocDat[k*WIDTH +: WIDTH];
         end
      end
   end

   assign fwd_dat = fwd_ring ? iRingDat : (fwd_loc ? loc_dat : '0);
   assign tail    = fwd_dat[WIDTH-1];
   assign rr_next = (sel_loc == IDXW'(NLOC - 1)) ? '0 : sel_loc + IDXW'(1);

   // Drive pops/write; everything is forced low while rst is held.
   always_comb begin
      oLocRdEn = '0;
      if (fwd_loc && !rst) begin
         for (int unsigned k = 0; k < NLOC; k++) begin
            oLocRdEn[k] = (sel_loc == IDXW'(k));
         end
      end
      oRingRdEn = fwd_ring && !rst;
      oDnWrEn   = (fwd_ring || fwd_loc) && !rst;
      oDnWrDat  = rst ? '0 : fwd_dat;
      oLock     = (state != IDLE) && !rst;
      oStarve   = starving && !rst;
   end

   // Packet lock state machine, owner and round-robin pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         owner  <= '0;
         rr_ptr <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (fwd_ring) begin
                  if (!tail) state <= RING_PKT;
               end else if (fwd_loc) begin
                  rr_ptr <= rr_next;
                  owner  <= sel_loc;
                  if (!tail) state <= LOC_PKT;
               end
            end
            RING_PKT: if (fwd_ring && tail) state <= IDLE;
            LOC_PKT:  if (fwd_loc && tail) state <= IDLE;
            default:  state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pt_ring_inject_arb.sv
// Directed testbench for pt_ring_inject_arb (WIDTH=8, NLOC=4, STARVE_MAX=2).
// Expectations follow PTRING_ARB_STARVE_EN when the bench is built with it.
module tb_pt_ring_inject_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        ring_ne;
   logic [7:0]  ring_dat;
   logic        ring_rd;
   logic [3:0]  loc_ne;
   logic [31:0] loc_dat;
   logic [3:0]  loc_rd;
   logic        dn_ful;
   logic        dn_wr;
   logic [7:0]  dn_dat;
   logic        lock;
   logic        starve;

   int checks = 0;
   int errors = 0;

   pt_ring_inject_arb #(
      .WIDTH      (8),
      .NLOC       (4),
      .STARVE_MAX (2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .iRingNotEmpty (ring_ne),
      .iRingDat      (ring_dat),
      .oRingRdEn     (ring_rd),
      .iLocNotEmpty  (loc_ne),
      .iLocDat       (loc_dat),
      .oLocRdEn      (loc_rd),
      .iDnFul        (dn_ful),
      .oDnWrEn       (dn_wr),
      .oDnWrDat      (dn_dat),
      .oLock         (lock),
      .oStarve       (starve)
   );

   always #5 clk = ~clk;

   // Expected output vector {ring_rd, loc_rd, dn_wr, dn_dat, lock, starve}.
   function automatic logic [15:0] e(input logic rr, input logic [3:0] lr,
                                     input logic [7:0] d, input logic lk,
                                     input logic st);
      return {rr, lr, rr | (|lr), d, lk, st};
   endfunction

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] expv);
      logic [15:0] obs;
      #1;
      obs = {ring_rd, loc_rd, dn_wr, dn_dat, lock, starve};
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset with all sources requesting: outputs must stay low.
      rst = 1'b1; ring_ne = 1'b1; ring_dat = 8'h85; loc_ne = 4'hF;
      loc_dat = 32'h93929190; dn_ful = 1'b0;
      next();
      chk("reset_outputs", 16'h0000);

      // Round-robin among single-flit locals 0, 2, 3.
      next(); rst = 1'b0; ring_ne = 1'b0; loc_ne = 4'b1101;
      chk("rr_grant0", e(1'b0, 4'b0001, 8'h90, 1'b0, 1'b0));
      next(); loc_ne = 4'b1100;
      chk("rr_grant2", e(1'b0, 4'b0100, 8'h92, 1'b0, 1'b0));
      next(); loc_ne = 4'b1000;
      chk("rr_grant3", e(1'b0, 4'b1000, 8'h93, 1'b0, 1'b0));
      next(); loc_ne = 4'b1011; loc_dat = 32'h93009180;
      chk("rr_wrap_to0", e(1'b0, 4'b0001, 8'h80, 1'b0, 1'b0));

      // Local 1 three-flit packet; ring flit shows up at cycle 2.
      next(); loc_ne = 4'b0010; loc_dat = 32'h00002100;
      chk("pkt_head", e(1'b0, 4'b0010, 8'h21, 1'b0, 1'b0));
      next(); loc_dat = 32'h00002200;
      chk("pkt_body", e(1'b0, 4'b0010, 8'h22, 1'b1, 1'b0));
      next(); loc_dat = 32'h0000A300; ring_ne = 1'b1; ring_dat = 8'h85;
      chk("pkt_tail_ring_wait", e(1'b0, 4'b0010, 8'hA3, 1'b1, 1'b0));
      next(); loc_ne = 4'b0000;
      chk("ring_after_tail", e(1'b1, 4'b0000, 8'h85, 1'b0, 1'b0));

      // Ring packet stalled by downstream full for two cycles.
      next(); ring_dat = 8'h41;
      chk("ring_head", e(1'b1, 4'b0000, 8'h41, 1'b0, 1'b0));
      next(); dn_ful = 1'b1; ring_dat = 8'h42; loc_ne = 4'b0100;
      loc_dat = 32'h00C40000;
      chk("stall1", e(1'b0, 4'b0000, 8'h00, 1'b1, 1'b0));
      next();
      chk("stall2", e(1'b0, 4'b0000, 8'h00, 1'b1, 1'b0));
      next(); dn_ful = 1'b0;
      chk("resume_body", e(1'b1, 4'b0000, 8'h42, 1'b1, 1'b0));
      next(); ring_dat = 8'hC3;
      chk("ring_tail", e(1'b1, 4'b0000, 8'hC3, 1'b1, 1'b0));
      next(); ring_ne = 1'b0; loc_ne = 4'b0000;
      chk("idle_after_ring", e(1'b0, 4'b0000, 8'h00, 1'b0, 1'b0));

      // Ring full of single flits with local 0 waiting.
      next(); ring_ne = 1'b1; ring_dat = 8'h80; loc_ne = 4'b0001;
      loc_dat = 32'h000000F0;
`ifdef PTRING_ARB_STARVE_EN
      chk("starve_ring0", e(1'b1, 4'b0000, 8'h80, 1'b0, 1'b0));
      next(); ring_dat = 8'h81;
      chk("starve_ring1", e(1'b1, 4'b0000, 8'h81, 1'b0, 1'b0));
      next(); ring_dat = 8'h82;
      chk("starve_local0", e(1'b0, 4'b0001, 8'hF0, 1'b0, 1'b1));
      next(); loc_ne = 4'b0000; ring_dat = 8'h83;
      chk("starve_ring_after", e(1'b1, 4'b0000, 8'h83, 1'b0, 1'b0));
`else
      for (int i = 0; i < 6; i++) begin
         if (i != 0) next();
         ring_dat = 8'h80 + 8'(i);
         chk("strict_ring", e(1'b1, 4'b0000, 8'h80 + 8'(i), 1'b0, 1'b0));
      end
`endif

      // Reset while local 2 owns the link.
      next(); ring_ne = 1'b0; loc_ne = 4'b0100; loc_dat = 32'h00120000;
      chk("head_loc2", e(1'b0, 4'b0100, 8'h12, 1'b0, 1'b0));
      next(); rst = 1'b1; ring_ne = 1'b1; loc_dat = 32'h00130000;
      chk("reset_mid_pkt", 16'h0000);
      next(); rst = 1'b0; ring_ne = 1'b0; loc_ne = 4'b1010;
      loc_dat = 32'h9B009A00;
      chk("after_reset_rr0", e(1'b0, 4'b0010, 8'h9A, 1'b0, 1'b0));

      // All sources empty for ten cycles, then check nothing moved.
      next(); loc_ne = 4'b0000; ring_dat = 8'hFF; loc_dat = 32'hFFFFFFFF;
      for (int i = 0; i < 10; i++) begin
         if (i != 0) next();
         chk("empty_idle", 16'h0000);
      end
      next(); dn_ful = 1'b1; loc_ne = 4'b1111; loc_dat = 32'h8F8E8D8C;
      chk("dnful_idle", 16'h0000);
      next(); dn_ful = 1'b0;
      chk("rr_held", e(1'b0, 4'b0100, 8'h8E, 1'b0, 1'b0));

      next();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
